// File: rtl/ram_stream_reader.sv
// Burst reader: fetches `length` consecutive words from a synchronous-read RAM
// starting at `base_addr` and presents them as a valid/ready stream.
// A 2-entry skid FIFO absorbs the one-cycle RAM read latency so the stream
// sustains one beat per cycle while never overrunning under back-pressure.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic pop;
  logic issue;
  logic last_issue;

  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign ram_addr = addr_q;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = fifo_data_q[rd_ptr_q];
  assign m_last   = m_valid & fifo_last_q[rd_ptr_q];
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  assign pop        = m_valid & m_ready;
  // Occupancy after this cycle (buffered + in-flight - popped) must stay below 2.
  assign issue      = (state_q == FETCH) && (issued_q < len_q) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign last_issue = ((issued_q + LEN_ONE) == len_q);

  // Next-state and burst bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    inflight_d  = issue;
    infl_last_d = issue & last_issue;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d   = base_addr;
            len_d    = length;
            issued_d = '0;
            state_d  = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          issued_d = issued_q + LEN_ONE;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // Output FIFO: capture returning read data, advance head on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= ram_dout;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: bursts push expected beats, a
// negedge monitor pops and compares every accepted beat and checks done timing.
module tb_ram_stream_reader;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: word i holds i & 0xFF, one-cycle read latency
  logic [DW-1:0] ram [1<<AW];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = i[7:0];
  always @(posedge clk) ram_dout <= ram[ram_addr];

  typedef struct { logic [7:0] data; logic last; int idx; } beat_t;
  beat_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rpat = 0;
  int pop_cnt = 0;
  int start_cyc = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int cur_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // m_ready driver: always high, or the 1,0,0 repeating pattern
  initial forever begin
    @(posedge clk); #1;
    rpat = (rpat + 1) % 3;
    m_ready = (ready_mode == 0) ? 1'b1 : (rpat == 0);
  end

  // Monitor: pops on accepted beats, checks stall stability and done timing
  logic          prev_last_pop = 1'b0;
  logic          prev_zero = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    logic  exp_done;
    logic  nxt_last;
    beat_t b;
    if (!rst_n) begin
      prev_last_pop = 1'b0;
      prev_zero     = 1'b0;
      stall_prev    = 1'b0;
    end else begin
      exp_done = prev_last_pop | prev_zero;
      if (done || exp_done) check("done_timing", done, exp_done);
      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      nxt_last = 1'b0;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with empty scoreboard (cycle %0d)", m_data, cyc);
        end else begin
          b = sb.pop_front();
          check("beat_data", m_data, b.data);
          check("beat_last", m_last, b.last);
          if (b.idx == 0) first_pop_cyc = cyc;
          if (b.last) last_pop_cyc = cyc;
          nxt_last = b.last;
        end
      end
      prev_last_pop = nxt_last;
      prev_zero     = start && (length == '0) && !busy;
      stall_prev    = m_valid && !m_ready;
      prev_data     = m_data;
    end
  end

  task automatic check_outputs_zero();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_addr", ram_addr, 0);
  endtask

  // Called at posedge+1; start is sampled by the next edge
  task automatic launch(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    beat_t b;
    for (int i = 0; i < len; i++) begin
      a = base + i[AW-1:0];
      b.data = a[7:0];
      b.last = (i == len - 1);
      b.idx  = i;
      sb.push_back(b);
    end
    cur_len   = len;
    base_addr = base;
    length    = len[AW:0];
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_complete(input bit timing);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 3000 cycles (cycle %0d)", cyc);
    end
    check("sb_drained", sb.size(), 0);
    if (timing) begin
      check("first_beat_latency", first_pop_cyc - start_cyc, 2);
      check("last_beat_cycle", last_pop_cyc - start_cyc, cur_len + 1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: 0x10..0x13, full rate, done right after last beat
    launch(10'h010, 4);
    wait_complete(1'b1);

    // Address wrap 0x3FE,0x3FF,0x000,0x001
    launch(10'h3FE, 4);
    wait_complete(1'b1);

    // Back-pressure 1,0,0 pattern
    ready_mode = 1;
    launch(10'h020, 8);
    wait_complete(1'b0);

    // Zero-length: done only, no beats, never busy
    ready_mode = 0;
    launch(10'h000, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("zero_valid", m_valid, 0);
      check("zero_busy_hold", busy, 0);
      @(posedge clk); #1;
    end

    // start during FETCH is ignored
    ready_mode = 1;
    launch(10'h100, 6);
    repeat (2) @(posedge clk);
    #1;
    check("fetch_busy", busy, 1);
    base_addr = 10'h200;
    length    = 11'd3;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_complete(1'b0);

    // Back-to-back: second start issued in the done cycle
    ready_mode = 0;
    launch(10'h040, 3);
    wait_complete(1'b1);
    launch(10'h080, 2);
    wait_complete(1'b1);

    // Full address space from 0x005
    launch(10'h005, 1 << AW);
    wait_complete(1'b1);

    // Reset after the third beat of a length-8 burst
    begin
      int base_pops;
      base_pops = pop_cnt;
      launch(10'h030, 8);
      for (int i = 0; i < 100 && pop_cnt < base_pops + 3; i++) begin
        @(negedge clk); #1;
      end
      check("pre_reset_pops", pop_cnt - base_pops, 3);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_reset_valid", m_valid, 0);
    end

    // Recovery burst after reset
    launch(10'h050, 2);
    wait_complete(1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the RAM word and stream data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, the RAM address width (2^ADDR_WIDTH words).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  burst request, sampled only in IDLE.
REQ-006 Port base_addr  input  ADDR_WIDTH  first RAM address of the burst.
REQ-007 Port length  input  ADDR_WIDTH+1  words in the burst, 0..2^ADDR_WIDTH.
REQ-008 Port ram_addr  output  ADDR_WIDTH  read address to a synchronous-read RAM port.
REQ-009 Port ram_we  output  1  RAM write enable, constant 0.
REQ-010 Port ram_din  output  DATA_WIDTH  RAM write data, constant 0.
REQ-011 Port ram_dout  input  DATA_WIDTH  RAM read data, valid one cycle after ram_addr is presented.
REQ-012 Port m_valid  output  1  stream data valid.
REQ-013 Port m_ready  input  1  stream consumer ready.
REQ-014 Port m_data  output  DATA_WIDTH  stream data.
REQ-015 Port m_last  output  1  high with the final beat of a burst.
REQ-016 Port busy  output  1  high in any state other than IDLE.
REQ-017 Port done  output  1  one-cycle pulse when the burst completes.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH and DRAIN.
REQ-019 In IDLE, start=1 with length>0 SHALL latch base_addr and length and enter FETCH.
REQ-020 In IDLE, start=1 with length=0 SHALL pulse done next cycle, produce no beats and stay in IDLE.
REQ-021 The block SHALL ignore start outside IDLE.
REQ-022 A read issue SHALL drive ram_addr with the current address in the same cycle and count the read as in-flight for one cycle.
REQ-023 Returning ram_dout SHALL be written into a 2-entry output FIFO on the following edge.
REQ-024 A read SHALL issue only when issued<length and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-025 With m_ready held high the block SHALL sustain one beat per cycle.
REQ-026 The address SHALL increment by 1 per issued read and wrap modulo 2^ADDR_WIDTH (e.g. 2^ADDR_WIDTH-1 -> 0).
REQ-027 The first m_valid SHALL assert on the second rising edge after the edge that samples start.
REQ-028 m_data and m_valid SHALL come from the FIFO head and stay stable while m_valid=1 and m_ready=0.
REQ-029 m_last SHALL be high only with the beat numbered length-1.
REQ-030 FETCH SHALL go to DRAIN in the cycle the last read issues.
REQ-031 DRAIN SHALL go to IDLE on the pop of the m_last beat, and done SHALL pulse in the following cycle.
REQ-032 A start in the cycle done is high SHALL be accepted (back-to-back bursts).
REQ-033 length=2^ADDR_WIDTH SHALL read every word exactly once, starting at base_addr.
REQ-034 The block SHALL never drop, duplicate or reorder a beat under any m_ready pattern.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, clear the FIFO, the in-flight flag and all counters, and drive m_valid, m_last, m_data, busy, done and ram_addr to 0.
REQ-036 Reset mid-burst SHALL abort the burst and discard any in-flight read data; no beat SHALL appear after reset deasserts without a new start.

Verification
REQ-037 base_addr=0x010, length=4, m_ready=1, RAM[i]=i&0xFF -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; m_last on 0x13; done one cycle later.
REQ-038 base_addr=0x3FE, length=4 -> ram_addr sequence 0x3FE,0x3FF,0x000,0x001 and data in that order.
REQ-039 length=8 with m_ready toggling 1,0,0,1,... -> all 8 beats in order, m_data stable while stalled, no more than 2 reads ever outstanding plus buffered.
REQ-040 start with length=0 -> done pulse, m_valid stays 0, busy stays 0.
REQ-041 rst_n pulsed low after the 3rd beat of a length=8 burst -> outputs 0 at once; after release m_valid stays 0 until the next start.
REQ-042 start asserted during FETCH with different base_addr -> ignored; the original burst completes unchanged.
